apb_cmd_sequencer: RTL and testbench

APB-domain sequencer between the bridge's request and response async FIFOs and the APB bus. It pops one command entry at a time from the request FIFO read port, runs a single APB SETUP/ACCESS transfer, and pushes read results, plus a timeout or slave-error flag, into the response FIFO write port. All logic runs on the APB clock; the FIFOs handle the clock-domain crossing.

---
 rtl/apb_cmd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// apb_cmd_sequencer
//
// APB-domain command sequencer. Pops one entry at a time from the request
// FIFO read port, runs a single APB SETUP/ACCESS transfer, and pushes read
// results (with an error flag) into the response FIFO write port. All logic
// runs on pclk; the FIFOs on either side handle the clock-domain crossing.
//
// Ports:
//   pclk, prst            APB clock, asynchronous active-high reset
//   en                    allows new entries to be popped
//   req_rempty/rdata/rinc request FIFO read port {write, addr, wdata}
//   resp_wfull/winc/wdata response FIFO write port {err, rdata}
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr  APB master
//   busy                  high whenever the FSM is not in IDLE
//   err_sticky, err_clr   sticky slave-error/timeout flag and its clear
//   xfer_cnt              count of completed (or timed-out) transfers
// ---------------------------------------------------------------------------
module apb_cmd_sequencer #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            pclk,
  input  logic            prst,
  input  logic            en,
  input  logic            req_rempty,
  input  logic [AW+DW:0]  req_rdata,
  output logic            req_rinc,
  input  logic            resp_wfull,
  output logic            resp_winc,
  output logic [DW:0]     resp_wdata,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  input  logic [DW-1:0]   prdata,
  input  logic            pready,
  input  logic            pslverr,
  output logic            busy,
  output logic            err_sticky,
  input  logic            err_clr,
  output logic [15:0]     xfer_cnt
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_ACCESS = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   wait_cnt_r;
  logic            done_s;
  logic            timeout_s;
  logic            exit_s;

  // pready takes priority over the timeout when both happen in the last cycle
  assign done_s    = (state_r == ST_ACCESS) && pready;
  assign timeout_s = (state_r == ST_ACCESS) && !pready &&
                     (wait_cnt_r == CW'(TIMEOUT - 1));
  assign exit_s    = done_s || timeout_s;

  // The push strobe must follow resp_wfull in the same cycle, so it is
  // decoded from the registered state rather than registered itself.
  assign resp_winc = (state_r == ST_RESP) && !resp_wfull;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en && !req_rempty) begin
          state_nxt_s = ST_POP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_POP:   state_nxt_s = ST_LOAD;
      ST_LOAD:  state_nxt_s = ST_SETUP;
      ST_SETUP: state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (exit_s) begin
          if (pwrite) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (!resp_wfull) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and control outputs registered from the next state, so
  // each strobe is glitch-free and lines up with the state it belongs to.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_r  <= ST_IDLE;
      req_rinc <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      req_rinc <= (state_nxt_s == ST_POP);
      psel     <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable  <= (state_nxt_s == ST_ACCESS);
      busy     <= (state_nxt_s != ST_IDLE);
    end
  end

  // ACCESS wait counter, cleared on the way into ACCESS
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_SETUP) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_ACCESS) && !exit_s) begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // APB address/data capture; held from SETUP through the end of ACCESS
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      pwrite <= 1'b0;
      paddr  <= {AW{1'b0}};
      pwdata <= {DW{1'b0}};
    end else if (state_r == ST_LOAD) begin
      pwrite <= req_rdata[AW+DW];
      paddr  <= req_rdata[AW+DW-1:DW];
      pwdata <= req_rdata[DW-1:0];
    end else begin
      pwrite <= pwrite;
      paddr  <= paddr;
      pwdata <= pwdata;
    end
  end

  // Read result capture; a timeout forces {err=1, rdata=0}
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      resp_wdata <= {(DW+1){1'b0}};
    end else if (exit_s && !pwrite) begin
      if (done_s) begin
        resp_wdata <= {pslverr, prdata};
      end else begin
        resp_wdata <= {1'b1, {DW{1'b0}}};
      end
    end else begin
      resp_wdata <= resp_wdata;
    end
  end

  // Sticky error flag; a new error in the same cycle as err_clr wins
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      err_sticky <= 1'b0;
    end else if ((done_s && pslverr) || timeout_s) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_sticky;
    end
  end

  // Transfer counter, bumped on every ACCESS exit including timeouts
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      xfer_cnt <= 16'd0;
    end else if (exit_s) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end else begin
      xfer_cnt <= xfer_cnt;
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for apb_cmd_sequencer. Directed vectors; expected APB transfers
// and expected response-FIFO pushes go into queues that independent monitor
// processes pop whenever the DUT presents a transfer or a push.
// ---------------------------------------------------------------------------
module tb_apb_cmd_sequencer;

  logic        pclk;
  logic        prst;
  logic        en;
  logic        req_rempty;
  logic [40:0] req_rdata;
  logic        req_rinc;
  logic        resp_wfull;
  logic        resp_winc;
  logic [32:0] resp_wdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        busy;
  logic        err_sticky;
  logic        err_clr;
  logic [15:0] xfer_cnt;

  apb_cmd_sequencer #(.AW(8), .DW(32), .TIMEOUT(64)) dut (
    .pclk(pclk), .prst(prst), .en(en),
    .req_rempty(req_rempty), .req_rdata(req_rdata), .req_rinc(req_rinc),
    .resp_wfull(resp_wfull), .resp_winc(resp_winc), .resp_wdata(resp_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr),
    .xfer_cnt(xfer_cnt)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          acc;   // expected ACCESS cycles, -1 = do not check
  } apb_t;

  apb_t        exp_apb[$];
  logic [32:0] exp_resp[$];
  logic [40:0] req_q[$];

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  int slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_req(input logic wr, input logic [7:0] a, input logic [31:0] d, input int acc);
    apb_t t;
    t.wr = wr; t.addr = a; t.wd = d; t.acc = acc;
    exp_apb.push_back(t);
    req_q.push_back({wr, a, d});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge pclk);
      if (i >= 2 && !busy && req_rempty) return;
    end
    bound_fail(name);
  endtask

  task automatic wait_access(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (psel && penable) return;
    end
    bound_fail(name);
  endtask

  // Request FIFO model: pop seen in a cycle updates rdata/empty after the edge
  initial begin
    logic p;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge pclk);
      p = req_rinc;
      if (req_rinc) begin
        pop_cnt++;
        check("rinc_while_empty", 64'(req_rempty), 64'd0);
        check("idle_before_pop", 64'(prev_busy), 64'd0);
      end
      prev_busy = busy;
      @(posedge pclk);
      #1;
      if (p && req_q.size() > 0) req_rdata = req_q.pop_front();
      req_rempty = (req_q.size() == 0);
    end
  end

  // APB slave model: pready after slv_wait extra ACCESS cycles
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (acc_cnt == slv_wait) begin
          pready = 1'b1; prdata = slv_rdata; pslverr = slv_err;
        end else begin
          pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
      end
    end
  end

  // APB monitor: compares each transfer and its ACCESS length
  initial begin
    apb_t cur;
    int   acc;
    logic in_xfer;
    in_xfer = 1'b0; acc = 0;
    cur.wr = 1'b0; cur.addr = 8'h0; cur.wd = 32'h0; cur.acc = -1;
    forever begin
      @(negedge pclk);
      if (psel && !penable) begin
        if (exp_apb.size() == 0) begin
          bound_fail("unexpected_apb_transfer");
        end else begin
          cur = exp_apb.pop_front();
          check("apb_pwrite", 64'(pwrite), 64'(cur.wr));
          check("apb_paddr", 64'(paddr), 64'(cur.addr));
          check("apb_pwdata", 64'(pwdata), 64'(cur.wd));
        end
        in_xfer = 1'b1; acc = 0;
      end else if (psel && penable) begin
        acc++;
        check("apb_addr_stable", 64'({pwrite, paddr, pwdata}), 64'({cur.wr, cur.addr, cur.wd}));
      end else if (in_xfer) begin
        in_xfer = 1'b0;
        if (cur.acc >= 0) check("apb_access_cycles", 64'(acc), 64'(cur.acc));
      end
    end
  end

  // Response monitor: every push must match the next expected result
  initial begin
    forever begin
      @(negedge pclk);
      if (resp_winc) begin
        if (exp_resp.size() == 0) begin
          bound_fail("unexpected_resp_push");
        end else begin
          check("resp_wdata", 64'(resp_wdata), 64'(exp_resp.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pops0;
    logic found;
    prst = 1'b1; en = 1'b1; resp_wfull = 1'b0; err_clr = 1'b0;
    req_rempty = 1'b1; req_rdata = 41'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    // Reset values
    repeat (3) @(posedge pclk);
    #1;
    check("rst_req_rinc", 64'(req_rinc), 64'd0);
    check("rst_resp_winc", 64'(resp_winc), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_resp_wdata", 64'(resp_wdata), 64'd0);
    check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    @(posedge pclk);
    #1 prst = 1'b0;

    // Zero-wait write with cycle-accurate latency
    slv_wait = 0; slv_err = 1'b0;
    push_req(1'b1, 8'h10, 32'hDEADBEEF, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge pclk);
      if (!req_rempty) found = 1'b1;
    end
    check("t1_entry_visible", 64'(found), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);
    @(negedge pclk);
    check("t1_n1_rinc", 64'({req_rinc, psel}), 64'b10);
    @(negedge pclk);
    check("t1_n2_load", 64'({req_rinc, psel, busy}), 64'b001);
    @(negedge pclk);
    check("t1_n3_setup", 64'({psel, penable}), 64'b10);
    @(negedge pclk);
    check("t1_n4_access", 64'({psel, penable, pwrite}), 64'b111);
    wait_idle("t1_idle_wait");
    check("t1_xfer_cnt", 64'(xfer_cnt), 64'd1);
    check("t1_err", 64'(err_sticky), 64'd0);

    // Read with three wait states
    slv_wait = 3; slv_rdata = 32'h12345678;
    push_req(1'b0, 8'h20, 32'h0, 4);
    exp_resp.push_back(33'h0_12345678);
    wait_idle("t2_idle_wait");
    check("t2_xfer_cnt", 64'(xfer_cnt), 64'd2);

    // Read with response FIFO full for 5 cycles
    resp_wfull = 1'b1; slv_wait = 0; slv_rdata = 32'hA5A50001;
    pops0 = pop_cnt;
    push_req(1'b0, 8'h30, 32'h0, 1);
    exp_resp.push_back(33'h0_A5A50001);
    wait_access("t3_access_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("t3_hold", 64'({busy, resp_winc, psel}), 64'b100);
      check("t3_wdata_stable", 64'(resp_wdata), 64'h0_A5A50001);
    end
    @(posedge pclk);
    #1 resp_wfull = 1'b0;
    @(negedge pclk);
    check("t3_push_cycle", 64'(resp_winc), 64'd1);
    @(negedge pclk);
    check("t3_back_idle", 64'({busy, resp_winc}), 64'b00);
    check("t3_single_pop", 64'(pop_cnt - pops0), 64'd1);

    // Timeout read, then set-wins-over-clear
    slv_wait = 1000;
    push_req(1'b0, 8'h40, 32'h0, 64);
    exp_resp.push_back({1'b1, 32'h0});
    wait_idle("t4_idle_wait");
    check("t4_err", 64'(err_sticky), 64'd1);
    check("t4_xfer_cnt", 64'(xfer_cnt), 64'd4);
    slv_wait = 0; slv_err = 1'b1;
    push_req(1'b1, 8'h50, 32'h00000001, 1);
    wait_access("t4b_access_wait");
    err_clr = 1'b1;
    @(posedge pclk);
    #1 err_clr = 1'b0;
    check("t4b_set_wins", 64'(err_sticky), 64'd1);
    slv_err = 1'b0;
    wait_idle("t4b_idle_wait");
    @(posedge pclk);
    #1 err_clr = 1'b1;
    @(posedge pclk);
    #1 err_clr = 1'b0;
    check("t4c_clear", 64'(err_sticky), 64'd0);
    check("t4c_xfer_cnt", 64'(xfer_cnt), 64'd5);

    // Three queued entries held off by en=0
    en = 1'b0; slv_rdata = 32'hCAFE0001;
    pops0 = pop_cnt;
    push_req(1'b1, 8'h60, 32'h11111111, 1);
    push_req(1'b0, 8'h61, 32'h0, 1);
    exp_resp.push_back(33'h0_CAFE0001);
    push_req(1'b1, 8'h62, 32'h22222222, 1);
    repeat (10) @(negedge pclk);
    check("t5_no_pop", 64'(pop_cnt - pops0), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    @(posedge pclk);
    #1 en = 1'b1;
    wait_idle("t5_idle_wait");
    check("t5_pops", 64'(pop_cnt - pops0), 64'd3);
    check("t5_xfer_cnt", 64'(xfer_cnt), 64'd8);

    // Reset pulsed during ACCESS
    slv_wait = 1000;
    push_req(1'b0, 8'h70, 32'h0, -1);
    wait_access("t6_access_wait");
    repeat (3) @(negedge pclk);
    #2 prst = 1'b1;
    #1;
    check("t6_async_bus", 64'({psel, penable, busy}), 64'b000);
    check("t6_async_cnt", 64'(xfer_cnt), 64'd0);
    @(posedge pclk);
    #1 prst = 1'b0;
    slv_wait = 0;
    push_req(1'b1, 8'h80, 32'h33333333, 1);
    wait_idle("t6_idle_wait");
    check("t6_xfer_cnt", 64'(xfer_cnt), 64'd1);
    check("t6_paddr", 64'(paddr), 64'h80);
    check("t6_err", 64'(err_sticky), 64'd0);

    repeat (3) @(negedge pclk);
    check("apb_queue_drained", 64'(exp_apb.size()), 64'd0);
    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
